// File: rtl/spi_flash_reader_if.sv
// -----------------------------------------------------------------------------
// spi_flash_reader_if
//   Request/response bundle between the boot/fetch path and the SPI flash
//   read engine.
//
//   req_valid / req_ready  : read request handshake
//   req_addr [31:0]        : byte address (only [23:0] reaches the flash)
//   req_cs                 : chip select index (0 -> spi_cs[0], 1 -> spi_cs[1])
//   rsp_valid / rsp_ready  : response handshake, data held until accepted
//   rsp_data [31:0]        : little-endian word, byte at req_addr in [7:0]
//
//   master : the requester (fetch path)
//   slave  : the read engine
// -----------------------------------------------------------------------------
interface spi_flash_reader_if;
  logic        req_valid;
  logic        req_ready;
  logic [31:0] req_addr;
  logic        req_cs;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_data;

  modport master (
    output req_valid, req_addr, req_cs, rsp_ready,
    input  req_ready, rsp_valid, rsp_data
  );

  modport slave (
    input  req_valid, req_addr, req_cs, rsp_ready,
    output req_ready, rsp_valid, rsp_data
  );
endinterface

// File: rtl/spi_flash_reader.sv
// -----------------------------------------------------------------------------
// spi_flash_reader
//   SPI mode-0 master that serves 32-bit word reads from a serial flash.
//   Each request sends READ (0x03) plus a 24-bit address, then clocks in four
//   bytes and returns them little-endian (first received byte in [7:0]).
//   spi_clk is produced by dividing sys_clk: each half period lasts CLK_DIV
//   sys_clk cycles.
//
//   Parameters
//     CLK_DIV   : spi_clk half period in sys_clk cycles, >= 1
//
//   Ports
//     sys_clk   : system clock, all logic on the rising edge
//     sys_rst   : synchronous active-high reset, drops any transfer in flight
//     bus       : request/response handshake (slave side)
//     spi_clk   : SPI clock, idles low
//     spi_cs    : active-low chip selects, at most one low at a time
//     spi_mosi  : serial data out, MSB first
//     spi_miso  : serial data in
// -----------------------------------------------------------------------------
module spi_flash_reader #(
  parameter int CLK_DIV = 2
) (
  input  logic               sys_clk,
  input  logic               sys_rst,
  spi_flash_reader_if.slave  bus,
  output logic               spi_clk,
  output logic [1:0]         spi_cs,
  output logic               spi_mosi,
  input  logic               spi_miso
);

  localparam int                DIV_W    = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [DIV_W-1:0]  DIV_LAST = DIV_W'(CLK_DIV - 1);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_SETUP = 2'd1;
  localparam logic [1:0] ST_SHIFT = 2'd2;
  localparam logic [1:0] ST_DONE  = 2'd3;

  localparam logic [7:0] CMD_READ = 8'h03;

  // Bit index counts completed falling edges: 0..31 are command/address,
  // 32..63 are data bits, 64 means the final low phase (CS hold) is running.
  localparam logic [6:0] BIT_DATA = 7'd32;
  localparam logic [6:0] BIT_LAST = 7'd64;

  logic [1:0]       state;
  logic [DIV_W-1:0] div_cnt;
  logic             div_wrap;
  logic [6:0]       bit_idx;
  logic [6:0]       bit_next;
  logic [31:0]      cmd_word;
  // Holds the command bits still to be sent after the one on spi_mosi.
  logic [30:0]      tx_sr;
  logic [31:0]      rx_sr;
  logic [31:0]      rx_swapped;
  logic             rsp_valid_q;
  logic [31:0]      rsp_data_q;

  // The upper address byte is not sent to the flash.
  logic             unused_addr_hi;
  assign unused_addr_hi = ^bus.req_addr[31:24];

  assign div_wrap   = (div_cnt == DIV_LAST);
  assign bit_next   = bit_idx + 7'd1;
  assign cmd_word   = {CMD_READ, bus.req_addr[23:0]};

  // First received byte sits in rx_sr[31:24] and belongs at the lowest address.
  assign rx_swapped = {rx_sr[7:0], rx_sr[15:8], rx_sr[23:16], rx_sr[31:24]};

  // A response is only ever pending in DONE, so IDLE alone implies no
  // outstanding response.
  assign bus.req_ready = (state == ST_IDLE);
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_data  = rsp_data_q;

  // NOTE: every register here is assigned with <= so that all of them see the
  // values from before the clock edge; mixing in = would make the result
  // depend on statement order.
  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      state       <= ST_IDLE;
      div_cnt     <= '0;
      bit_idx     <= '0;
      tx_sr       <= '0;
      rx_sr       <= '0;
      rsp_valid_q <= 1'b0;
      rsp_data_q  <= '0;
      spi_clk     <= 1'b0;
      spi_cs      <= 2'b11;
      spi_mosi    <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (bus.req_valid) begin
            tx_sr    <= cmd_word[30:0];
            spi_mosi <= cmd_word[31];
            spi_cs   <= bus.req_cs ? 2'b01 : 2'b10;
            div_cnt  <= '0;
            bit_idx  <= '0;
            state    <= ST_SETUP;
          end
        end

        ST_SETUP: begin
          if (div_wrap) begin
            // First rising edge; bit index is 0, so nothing is sampled yet.
            div_cnt <= '0;
            spi_clk <= 1'b1;
            state   <= ST_SHIFT;
          end else begin
            div_cnt <= div_cnt + DIV_W'(1);
          end
        end

        ST_SHIFT: begin
          if (!div_wrap) begin
            div_cnt <= div_cnt + DIV_W'(1);
          end else begin
            div_cnt <= '0;
            if (spi_clk) begin
              // Falling edge: the flash has sampled the current bit.
              spi_clk  <= 1'b0;
              bit_idx  <= bit_next;
              tx_sr    <= {tx_sr[29:0], 1'b0};
              spi_mosi <= (bit_next < BIT_DATA) ? tx_sr[30] : 1'b0;
            end else if (bit_idx == BIT_LAST) begin
              // End of the CS hold after the 64th falling edge.
              spi_cs      <= 2'b11;
              rsp_valid_q <= 1'b1;
              rsp_data_q  <= rx_swapped;
              state       <= ST_DONE;
            end else begin
              // Rising edge: data bits are captured from the 33rd rise on.
              spi_clk <= 1'b1;
              if (bit_idx >= BIT_DATA) begin
                rx_sr <= {rx_sr[30:0], spi_miso};
              end
            end
          end
        end

        ST_DONE: begin
          if (bus.rsp_ready) begin
            rsp_valid_q <= 1'b0;
            state       <= ST_IDLE;
          end
        end

        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_spi_flash_reader.sv
// -----------------------------------------------------------------------------
// tb_spi_flash_reader
//   Two engines share one reset: unit 0 with CLK_DIV=2, unit 1 with CLK_DIV=1.
//   Each has a behavioural mode-0 flash model on its SPI pins. Expected read
//   words are pushed to a scoreboard queue when a request is driven and
//   compared when the response is accepted.
// -----------------------------------------------------------------------------
module tb_spi_flash_reader;

  localparam int H0 = 2;
  localparam int H1 = 1;

  logic sys_clk = 1'b0;
  logic sys_rst;
  always #5 sys_clk = ~sys_clk;

  // Requester side, indexed by unit.
  logic        req_valid   [2];
  logic [31:0] req_addr    [2];
  logic        req_cs      [2];
  logic        rsp_ready   [2];
  logic        req_ready_o [2];
  logic        rsp_valid_o [2];
  logic [31:0] rsp_data_o  [2];

  // SPI pins, indexed by unit.
  logic        spi_clk  [2];
  logic [1:0]  spi_cs   [2];
  logic        spi_mosi [2];
  logic        spi_miso [2] = '{1'b0, 1'b0};

  spi_flash_reader_if bus0 ();
  spi_flash_reader_if bus1 ();

  assign bus0.req_valid = req_valid[0];
  assign bus0.req_addr  = req_addr[0];
  assign bus0.req_cs    = req_cs[0];
  assign bus0.rsp_ready = rsp_ready[0];
  assign req_ready_o[0] = bus0.req_ready;
  assign rsp_valid_o[0] = bus0.rsp_valid;
  assign rsp_data_o[0]  = bus0.rsp_data;

  assign bus1.req_valid = req_valid[1];
  assign bus1.req_addr  = req_addr[1];
  assign bus1.req_cs    = req_cs[1];
  assign bus1.rsp_ready = rsp_ready[1];
  assign req_ready_o[1] = bus1.req_ready;
  assign rsp_valid_o[1] = bus1.rsp_valid;
  assign rsp_data_o[1]  = bus1.rsp_data;

  spi_flash_reader #(.CLK_DIV(H0)) u_dut0 (
    .sys_clk  (sys_clk),
    .sys_rst  (sys_rst),
    .bus      (bus0),
    .spi_clk  (spi_clk[0]),
    .spi_cs   (spi_cs[0]),
    .spi_mosi (spi_mosi[0]),
    .spi_miso (spi_miso[0])
  );

  spi_flash_reader #(.CLK_DIV(H1)) u_dut1 (
    .sys_clk  (sys_clk),
    .sys_rst  (sys_rst),
    .bus      (bus1),
    .spi_clk  (spi_clk[1]),
    .spi_cs   (spi_cs[1]),
    .spi_mosi (spi_mosi[1]),
    .spi_miso (spi_miso[1])
  );

  // ---------------------------------------------------------------------------
  // Checking
  // ---------------------------------------------------------------------------
  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Flash content: a few fixed words at the bottom, a pattern elsewhere
  // ---------------------------------------------------------------------------
  function automatic logic [7:0] flash_byte(input logic [23:0] a);
    case (a)
      24'h000000: flash_byte = 8'h13;
      24'h000001: flash_byte = 8'h05;
      24'h000002: flash_byte = 8'h00;
      24'h000003: flash_byte = 8'h00;
      24'h000004: flash_byte = 8'h37;
      24'h000005: flash_byte = 8'h01;
      24'h000006: flash_byte = 8'h00;
      24'h000007: flash_byte = 8'h20;
      default:    flash_byte = a[7:0] ^ a[15:8] ^ a[23:16] ^ 8'h5A;
    endcase
  endfunction

  function automatic logic [31:0] flash_word(input logic [23:0] a);
    flash_word = {flash_byte(a + 24'd3), flash_byte(a + 24'd2),
                  flash_byte(a + 24'd1), flash_byte(a)};
  endfunction

  // ---------------------------------------------------------------------------
  // Mode-0 flash model: samples MOSI on rising spi_clk, drives MISO after
  // falling spi_clk. Runs on the opposite sys_clk edge to the DUT.
  // ---------------------------------------------------------------------------
  logic        m_active    [2] = '{1'b0, 1'b0};
  logic        m_prev_clk  [2] = '{1'b0, 1'b0};
  int          m_rises     [2] = '{0, 0};
  logic [31:0] m_cmd       [2] = '{32'd0, 32'd0};
  logic [1:0]  m_cs        [2] = '{2'b11, 2'b11};
  logic [31:0] m_last_cmd  [2] = '{32'd0, 32'd0};
  int          m_last_rises[2] = '{0, 0};
  logic [1:0]  m_last_cs   [2] = '{2'b11, 2'b11};
  logic        m_both_low  = 1'b0;
  logic        m_cs_change = 1'b0;

  task automatic flash_step(input int u);
    int         k;
    logic [7:0] b;
    if (spi_cs[u] == 2'b11) begin
      if (m_active[u]) begin
        m_last_cmd[u]   = m_cmd[u];
        m_last_rises[u] = m_rises[u];
        m_last_cs[u]    = m_cs[u];
        m_active[u]     = 1'b0;
      end
      m_rises[u]  = 0;
      spi_miso[u] = 1'b0;
    end else begin
      if (!m_active[u]) begin
        m_active[u] = 1'b1;
        m_cs[u]     = spi_cs[u];
        m_cmd[u]    = '0;
      end else if (spi_cs[u] != m_cs[u]) begin
        m_cs_change = 1'b1;
      end
      if (spi_cs[u] == 2'b00) m_both_low = 1'b1;
      if (spi_clk[u] && !m_prev_clk[u]) begin
        if (m_rises[u] < 32) m_cmd[u] = {m_cmd[u][30:0], spi_mosi[u]};
        m_rises[u]++;
      end else if (!spi_clk[u] && m_prev_clk[u]) begin
        if (m_rises[u] >= 32 && m_rises[u] < 64) begin
          k           = m_rises[u] - 32;
          b           = flash_byte(m_cmd[u][23:0] + 24'(k / 8));
          spi_miso[u] = b[7 - (k % 8)];
        end else begin
          spi_miso[u] = 1'b0;
        end
      end
    end
    m_prev_clk[u] = spi_clk[u];
  endtask

  always @(negedge sys_clk) begin
    for (int u = 0; u < 2; u++) flash_step(u);
  end

  // ---------------------------------------------------------------------------
  // Scoreboard and stimulus
  // ---------------------------------------------------------------------------
  logic [31:0] exp_q[$];

  task automatic do_read(input int u, input logic [31:0] addr, input logic sel, input int stall);
    int          h;
    int          rel;
    int          cs_low;
    int          r1;
    int          r2;
    logic        prev;
    logic        stable;
    logic [31:0] held;
    h = (u == 0) ? H0 : H1;

    @(negedge sys_clk);
    check("req_ready before request", 32'(req_ready_o[u]), 32'd1);
    req_valid[u] = 1'b1;
    req_addr[u]  = addr;
    req_cs[u]    = sel;
    exp_q.push_back(flash_word(addr[23:0]));
    @(posedge sys_clk);
    #1 req_valid[u] = 1'b0;

    rel = 0; cs_low = 0; r1 = -1; r2 = -1; prev = 1'b0;
    while (rel < 2000) begin
      @(negedge sys_clk);
      rel++;
      if (rsp_valid_o[u]) break;
      if (spi_cs[u] != 2'b11) cs_low++;
      if (spi_clk[u] && !prev) begin
        if (r1 < 0) r1 = rel;
        else if (r2 < 0) r2 = rel;
      end
      prev = spi_clk[u];
    end
    check("rsp_valid latency", 32'(rel), 32'(1 + 129 * h));
    check("cs low cycles", 32'(cs_low), 32'(129 * h));
    check("first spi_clk rise", 32'(r1), 32'(1 + h));
    check("spi_clk period", 32'(r2 - r1), 32'(2 * h));
    check("cs high with rsp_valid", 32'(spi_cs[u]), 32'h3);

    #1;
    check("mosi command", m_last_cmd[u], {8'h03, addr[23:0]});
    check("spi_clk rises", 32'(m_last_rises[u]), 32'd64);
    check("cs selected", 32'(m_last_cs[u]), sel ? 32'h1 : 32'h2);

    held   = rsp_data_o[u];
    stable = 1'b1;
    for (int i = 0; i < stall; i++) begin
      @(negedge sys_clk);
      if (!rsp_valid_o[u] || rsp_data_o[u] !== held || req_ready_o[u] || spi_cs[u] != 2'b11)
        stable = 1'b0;
    end
    if (stall > 0) check("hold while stalled", 32'(stable), 32'd1);

    rsp_ready[u] = 1'b1;
    check("rsp_data", rsp_data_o[u], exp_q.pop_front());
    @(posedge sys_clk);
    #1 rsp_ready[u] = 1'b0;
    @(negedge sys_clk);
    check("rsp_valid after accept", 32'(rsp_valid_o[u]), 32'd0);
    check("req_ready after accept", 32'(req_ready_o[u]), 32'd1);
  endtask

  task automatic reset_mid_shift();
    logic seen;
    @(negedge sys_clk);
    req_valid[0] = 1'b1;
    req_addr[0]  = 32'h0000_0010;
    req_cs[0]    = 1'b0;
    @(posedge sys_clk);
    #1 req_valid[0] = 1'b0;
    repeat (100) @(negedge sys_clk);
    sys_rst = 1'b1;
    @(negedge sys_clk);
    check("cs after mid reset", 32'(spi_cs[0]), 32'h3);
    check("spi_clk after mid reset", 32'(spi_clk[0]), 32'd0);
    check("rsp_valid after mid reset", 32'(rsp_valid_o[0]), 32'd0);
    @(negedge sys_clk);
    sys_rst = 1'b0;
    seen = 1'b0;
    repeat (400) begin
      @(negedge sys_clk);
      if (rsp_valid_o[0] || spi_cs[0] != 2'b11) seen = 1'b1;
    end
    check("dropped transfer stays quiet", 32'(seen), 32'd0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL global timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    logic [31:0] a;
    sys_rst = 1'b1;
    for (int u = 0; u < 2; u++) begin
      req_valid[u] = 1'b0;
      req_addr[u]  = '0;
      req_cs[u]    = 1'b0;
      rsp_ready[u] = 1'b0;
    end
    repeat (4) @(posedge sys_clk);
    @(negedge sys_clk);
    sys_rst = 1'b0;
    @(negedge sys_clk);
    check("reset spi_cs", 32'(spi_cs[0]), 32'h3);
    check("reset spi_clk", 32'(spi_clk[0]), 32'd0);
    check("reset spi_mosi", 32'(spi_mosi[0]), 32'd0);
    check("reset rsp_valid", 32'(rsp_valid_o[0]), 32'd0);
    check("reset rsp_data", rsp_data_o[0], 32'd0);
    check("reset req_ready", 32'(req_ready_o[0]), 32'd1);
    check("reset spi_cs unit1", 32'(spi_cs[1]), 32'h3);

    do_read(0, 32'h0000_0000, 1'b0, 0);
    do_read(0, 32'h0000_0104, 1'b0, 10);
    do_read(0, 32'hAB12_3456, 1'b1, 0);
    reset_mid_shift();
    do_read(0, 32'h0000_0000, 1'b0, 0);
    do_read(1, 32'h0000_0004, 1'b0, 0);

    for (int i = 0; i < 3; i++) begin
      a = $urandom;
      do_read(i % 2, a, 1'($urandom_range(0, 1)), $urandom_range(0, 3));
    end

    check("cs both low never", 32'(m_both_low), 32'd0);
    check("cs steady during transfer", 32'(m_cs_change), 32'd0);
    check("scoreboard drained", 32'(exp_q.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
